// File: rtl/mips_rf_pkg.sv
// Shared register-file definitions: address/data widths, the zero register and the write-entry payload.
package mips_rf_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of register write entries; simultaneous push and pop are allowed when full.
module rf_wb_fifo
  import mips_rf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t pop_data,
  output logic      full,
  output logic      empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  // Payload storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/regfile_write_sequencer.sv
// Sole writer of the GPR write port: arbitrates the WB stage against buffered long-latency results.
// Optional same-cycle read bypass ports are enabled with RF_BYPASS_EN.
module regfile_write_sequencer
  import mips_rf_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [REG_DATA_W-1:0] wb_data,
  output logic                  wb_stall,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [REG_ADDR_W-1:0] lu_addr,
  input  logic [REG_DATA_W-1:0] lu_data,
  output logic [REG_ADDR_W-1:0] Rd_addr,
  output logic [REG_DATA_W-1:0] Rd_data,
  output logic                  RegWrite,
  output logic                  fifo_empty
`ifdef RF_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0] byp_rs_addr,
  input  logic [REG_ADDR_W-1:0] byp_rt_addr,
  output logic                  byp_rs_hit,
  output logic                  byp_rt_hit,
  output logic [REG_DATA_W-1:0] byp_rs_data,
  output logic [REG_DATA_W-1:0] byp_rt_data
`endif
);

  localparam int unsigned STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  wb_entry_t           push_entry;
  wb_entry_t           head;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                force_pop;
  logic                wb_req;
  logic                wb_take;
  logic [STARVE_W-1:0] starve_cnt;

  assign push_entry = '{addr: lu_addr, data: lu_data};

  rf_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  // Arbitration: a starved FIFO head beats the pipeline, otherwise the pipeline has priority.
  always_comb begin
    force_pop = (starve_cnt == STARVE_W'(STARVE_LIMIT)) && !empty;
    wb_req    = wb_valid && (wb_addr != REG_ZERO);
    pop       = force_pop || (!wb_req && !empty);
    wb_take   = wb_req && !force_pop;
    wb_stall  = wb_req && force_pop;
    lu_ready  = !full || pop;
    push      = lu_valid && lu_ready && (lu_addr != REG_ZERO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (pop) begin
      starve_cnt <= '0;
    end else if (wb_take && !empty && (starve_cnt != STARVE_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  // Registered write port; address/data hold their last value when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite <= 1'b0;
      Rd_addr  <= '0;
      Rd_data  <= '0;
    end else begin
      RegWrite <= pop || wb_take;
      if (pop) begin
        Rd_addr <= head.addr;
        Rd_data <= head.data;
      end else if (wb_take) begin
        Rd_addr <= wb_addr;
        Rd_data <= wb_data;
      end
    end
  end

  assign fifo_empty = empty;

`ifdef RF_BYPASS_EN
  // Forward the in-flight write to same-cycle register file reads.
  always_comb begin
    byp_rs_hit  = RegWrite && (Rd_addr == byp_rs_addr) && (byp_rs_addr != REG_ZERO);
    byp_rt_hit  = RegWrite && (Rd_addr == byp_rt_addr) && (byp_rt_addr != REG_ZERO);
    byp_rs_data = byp_rs_hit ? Rd_data : '0;
    byp_rt_data = byp_rt_hit ? Rd_data : '0;
  end
`endif

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Directed bench for regfile_write_sequencer; bypass checks are compiled in with RF_BYPASS_EN.
module tb_regfile_write_sequencer;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic [4:0]  Rd_addr;
  logic [31:0] Rd_data;
  logic        RegWrite;
  logic        fifo_empty;
`ifdef RF_BYPASS_EN
  logic [4:0]  byp_rs_addr;
  logic [4:0]  byp_rt_addr;
  logic        byp_rs_hit;
  logic        byp_rt_hit;
  logic [31:0] byp_rs_data;
  logic [31:0] byp_rt_data;
`endif

  int checks = 0;
  int errors = 0;

  regfile_write_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wb_stall   (wb_stall),
    .lu_valid   (lu_valid),
    .lu_ready   (lu_ready),
    .lu_addr    (lu_addr),
    .lu_data    (lu_data),
    .Rd_addr    (Rd_addr),
    .Rd_data    (Rd_data),
    .RegWrite   (RegWrite),
    .fifo_empty (fifo_empty)
`ifdef RF_BYPASS_EN
    ,
    .byp_rs_addr (byp_rs_addr),
    .byp_rt_addr (byp_rt_addr),
    .byp_rs_hit  (byp_rs_hit),
    .byp_rt_hit  (byp_rt_hit),
    .byp_rs_data (byp_rs_data),
    .byp_rt_data (byp_rt_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] addr, input logic [31:0] data);
    chk({tag, "_we"}, 32'(RegWrite), 32'd1);
    chk({tag, "_addr"}, 32'(Rd_addr), 32'(addr));
    chk({tag, "_data"}, Rd_data, data);
  endtask

  function automatic logic [31:0] wbd(input int a);
    return 32'hA000_0000 | 32'(a);
  endfunction

  function automatic logic [31:0] lud(input int a);
    return 32'hB000_0000 | 32'(a);
  endfunction

  initial begin
    rst_n    = 1'b0;
    wb_valid = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    lu_valid = 1'b0;
    lu_addr  = '0;
    lu_data  = '0;
`ifdef RF_BYPASS_EN
    byp_rs_addr = '0;
    byp_rt_addr = '0;
`endif

    // Reset state
    #2;
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_rd_addr", 32'(Rd_addr), 32'd0);
    chk("rst_rd_data", Rd_data, 32'd0);
    chk("rst_wb_stall", 32'(wb_stall), 32'd0);
    chk("rst_lu_ready", 32'(lu_ready), 32'd1);
    chk("rst_fifo_empty", 32'(fifo_empty), 32'd1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // 1: simple pipeline write, one-cycle latency
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    #1 chk("t1_stall", 32'(wb_stall), 32'd0);
    tick();
    chk_wr("t1", 5'd5, 32'hDEADBEEF);

    // 2: writes to r0 from either stream are dropped
    wb_addr = 5'd0; wb_data = 32'h1234_5678;
    lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 32'h5555_AAAA;
    #1 chk("t2_stall", 32'(wb_stall), 32'd0);
    chk("t2_lu_ready", 32'(lu_ready), 32'd1);
    tick();
    wb_valid = 1'b0; lu_valid = 1'b0;
    chk("t2_regwrite", 32'(RegWrite), 32'd0);
    chk("t2_fifo_empty", 32'(fifo_empty), 32'd1);

    // 3: four lu entries with wb idle drain in arrival order
    for (int k = 0; k < 4; k++) begin
      lu_valid = 1'b1; lu_addr = 5'(8 + k); lu_data = lud(8 + k);
      #1 chk("t3_lu_ready", 32'(lu_ready), 32'd1);
      tick();
      if (k == 0) chk("t3_first_idle", 32'(RegWrite), 32'd0);
      else        chk_wr("t3_order", 5'(7 + k), lud(7 + k));
    end
    lu_valid = 1'b0;
    tick();
    chk_wr("t3_last", 5'd11, lud(11));
    chk("t3_empty", 32'(fifo_empty), 32'd1);
    tick();
    chk("t3_idle", 32'(RegWrite), 32'd0);

    // 4: anti-starvation forces r7 through after losing three cycles
    lu_valid = 1'b1; lu_addr = 5'd7; lu_data = lud(7);
    for (int i = 1; i <= 4; i++) begin
      wb_valid = 1'b1; wb_addr = 5'(i); wb_data = wbd(i);
      #1 chk("t4_no_stall", 32'(wb_stall), 32'd0);
      tick();
      lu_valid = 1'b0;
      chk_wr("t4_wb", 5'(i), wbd(i));
    end
    wb_addr = 5'd5; wb_data = wbd(5);
    #1 chk("t4_stall", 32'(wb_stall), 32'd1);
    tick();
    chk_wr("t4_forced", 5'd7, lud(7));
    chk("t4_held_no_stall", 32'(wb_stall), 32'd0);
    tick();
    chk_wr("t4_held", 5'd5, wbd(5));
    wb_valid = 1'b0;
    tick();

    // 5: fill to 4, push during a forced pop, then full with no pop refuses
    for (int k = 0; k < 4; k++) begin
      wb_valid = 1'b1; wb_addr = 5'(20 + k); wb_data = wbd(20 + k);
      lu_valid = 1'b1; lu_addr = 5'(12 + k); lu_data = lud(12 + k);
      #1 chk("t5_fill_ready", 32'(lu_ready), 32'd1);
      tick();
      chk_wr("t5_wb", 5'(20 + k), wbd(20 + k));
    end
    wb_addr = 5'd24; wb_data = wbd(24);
    lu_addr = 5'd16; lu_data = lud(16);
    #1 chk("t5_full_pop_ready", 32'(lu_ready), 32'd1);
    chk("t5_force_stall", 32'(wb_stall), 32'd1);
    tick();
    chk_wr("t5_forced", 5'd12, lud(12));
    lu_valid = 1'b0;
    #1 chk("t5_full_not_ready", 32'(lu_ready), 32'd0);
    chk("t5_not_empty", 32'(fifo_empty), 32'd0);
    tick();
    chk_wr("t5_wb24", 5'd24, wbd(24));
    wb_valid = 1'b0;
    for (int k = 13; k <= 16; k++) begin
      tick();
      chk_wr("t5_drain", 5'(k), lud(k));
    end
    chk("t5_empty", 32'(fifo_empty), 32'd1);
    tick();
    chk("t5_idle", 32'(RegWrite), 32'd0);

    // 6: reset discards three buffered entries
    for (int k = 0; k < 3; k++) begin
      wb_valid = 1'b1; wb_addr = 5'(25 + k); wb_data = wbd(25 + k);
      lu_valid = 1'b1; lu_addr = 5'(17 + k); lu_data = lud(17 + k);
      tick();
    end
    lu_valid = 1'b0;
    chk("t6_buffered", 32'(fifo_empty), 32'd0);
    chk("t6_pre_we", 32'(RegWrite), 32'd1);
    #2;
    wb_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_we", 32'(RegWrite), 32'd0);
    chk("t6_rst_empty", 32'(fifo_empty), 32'd1);
    chk("t6_rst_ready", 32'(lu_ready), 32'd1);
    tick();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_no_write", 32'(RegWrite), 32'd0);
    end
    chk("t6_empty_after", 32'(fifo_empty), 32'd1);

`ifdef RF_BYPASS_EN
    // Bypass of an in-flight r3 write
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = wbd(3);
    tick();
    wb_valid = 1'b0;
    byp_rs_addr = 5'd3; byp_rt_addr = 5'd4;
    #1;
    chk("byp_rs_hit", 32'(byp_rs_hit), 32'd1);
    chk("byp_rs_data", byp_rs_data, wbd(3));
    chk("byp_rt_miss", 32'(byp_rt_hit), 32'd0);
    tick();
    chk("byp_rs_idle", 32'(byp_rs_hit), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
